// File: rtl/cpu_register_bank.sv
// Eight-entry general-purpose register bank: one write port, two combinational reads, PC increment, freezable shadow copy.
// Define CPU_REGISTER_BANK_BYPASS_EN to forward same-cycle write data onto the read ports.
module cpu_register_bank #(
    parameter int WIDTH  = 16,
    parameter int PC_IDX = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pc_inc,
    input  logic [2:0]       rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [2:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             freeze,
    input  logic             dirty_clr,
    output logic [7:0]       dirty,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic [WIDTH-1:0] r8
);

    localparam logic [2:0]       PC_SEL = 3'(PC_IDX);
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs   [8];
    logic [WIDTH-1:0] shadow [8];
    logic [7:0]       wr_hit;
    logic [7:0]       pc_hit;
    logic [7:0]       set_vec;

    // A write to the PC entry masks the increment for that entry only.
    always_comb begin
        wr_hit = '0;
        pc_hit = '0;
        if (wr_en)
            wr_hit[wr_addr] = 1'b1;
        if (pc_inc)
            pc_hit[PC_SEL] = 1'b1;
        pc_hit  = pc_hit & ~wr_hit;
        set_vec = wr_hit | pc_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i]   <= '0;
                shadow[i] <= '0;
            end
            dirty <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_hit[i])
                    regs[i] <= wr_data;
                else if (pc_hit[i])
                    regs[i] <= regs[i] + ONE;
                if (!freeze)
                    shadow[i] <= regs[i];
            end
            // Set events beat a same-cycle clear.
            dirty <= (dirty_clr ? 8'h00 : dirty) | set_vec;
        end
    end

`ifdef CPU_REGISTER_BANK_BYPASS_EN
    assign rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : regs[rd_addr_a];
    assign rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : regs[rd_addr_b];
`else
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
`endif

    assign r1 = shadow[0];
    assign r2 = shadow[1];
    assign r3 = shadow[2];
    assign r4 = shadow[3];
    assign r5 = shadow[4];
    assign r6 = shadow[5];
    assign r7 = shadow[6];
    assign r8 = shadow[7];

endmodule

// File: tb/tb_cpu_register_bank.sv
// Self-checking bench for cpu_register_bank: directed scenarios then randomized traffic against an array-based model.
module tb_cpu_register_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        pc_inc;
    logic [2:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic        freeze;
    logic        dirty_clr;
    logic [7:0]  dirty;
    logic [15:0] r1, r2, r3, r4, r5, r6, r7, r8;
    logic [15:0] r_obs [8];

    int checks   = 0;
    int failures = 0;

    int unsigned m_reg [8];
    int unsigned m_shd [8];
    bit [7:0]    m_dirty;

    cpu_register_bank #(.WIDTH(16), .PC_IDX(7)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pc_inc(pc_inc),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .freeze(freeze), .dirty_clr(dirty_clr), .dirty(dirty),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7), .r8(r8)
    );

    assign r_obs[0] = r1;
    assign r_obs[1] = r2;
    assign r_obs[2] = r3;
    assign r_obs[3] = r4;
    assign r_obs[4] = r5;
    assign r_obs[5] = r6;
    assign r_obs[6] = r7;
    assign r_obs[7] = r8;

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_rd(logic [2:0] a);
`ifdef CPU_REGISTER_BANK_BYPASS_EN
        if (wr_en && wr_addr == a)
            return wr_data;
`endif
        return 16'(m_reg[a]);
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reads(string tag);
        chk({tag, "_rda"}, rd_data_a, exp_rd(rd_addr_a));
        chk({tag, "_rdb"}, rd_data_b, exp_rd(rd_addr_b));
    endtask

    task automatic chk_all(string tag);
        chk_reads(tag);
        chk({tag, "_dirty"}, {8'h00, dirty}, {8'h00, m_dirty});
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_r%0d", tag, i + 1), r_obs[i], 16'(m_shd[i]));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = 0;
            m_shd[i] = 0;
        end
        m_dirty = 8'h00;
    endtask

    // Model one rising edge from the currently driven inputs, then advance to edge+1.
    task automatic tick();
        int unsigned nreg [8];
        bit [7:0]    nd;
        nreg = m_reg;
        nd   = dirty_clr ? 8'h00 : m_dirty;
        if (wr_en) begin
            nreg[wr_addr] = wr_data;
            nd[wr_addr]   = 1'b1;
        end
        if (pc_inc && !(wr_en && wr_addr == 3'd7)) begin
            nreg[7] = (m_reg[7] + 1) % 65536;
            nd[7]   = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!freeze)
            m_shd = m_reg;
        m_reg   = nreg;
        m_dirty = nd;
    endtask

    task automatic do_write(logic [2:0] a, logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; pc_inc = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; freeze = 1'b0; dirty_clr = 1'b0;
        model_reset();
        #3;
        chk_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("post_rst");

        // basic write and two-edge shadow latency
        rd_addr_a = 3'd3;
        do_write(3'd3, 16'hA5A5);
        chk("wr3_rda", rd_data_a, 16'hA5A5);
        chk("wr3_dirty", {8'h00, dirty}, 16'h0008);
        chk("wr3_r4_early", r4, 16'h0000);
        tick();
        chk("wr3_r4", r4, 16'hA5A5);
        chk_all("wr3");

        // PC wrap and write-over-increment priority
        rd_addr_b = 3'd7;
        do_write(3'd7, 16'hFFFE);
        pc_inc = 1'b1;
        tick();
        chk("pc_ffff", rd_data_b, 16'hFFFF);
        tick();
        chk("pc_wrap", rd_data_b, 16'h0000);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h1234;
        tick();
        wr_en = 1'b0; pc_inc = 1'b0;
        chk("pc_wr_wins", rd_data_b, 16'h1234);
        tick();
        chk("pc_r8", r8, 16'h1234);
        chk_all("pc");

        // freeze holds shadows while the entry moves on
        rd_addr_a = 3'd0;
        do_write(3'd0, 16'h0001);
        tick();
        freeze = 1'b1;
        do_write(3'd0, 16'h0002);
        tick();
        chk("frz_r1", r1, 16'h0001);
        chk("frz_rda", rd_data_a, 16'h0002);
        chk_all("frz");
        freeze = 1'b0;
        tick();
        chk("unfrz_r1", r1, 16'h0002);

        // dirty clear racing a write
        for (int i = 0; i < 8; i++)
            do_write(3'(i), 16'($urandom));
        chk("dirty_all", {8'h00, dirty}, 16'h00FF);
        dirty_clr = 1'b1;
        do_write(3'd5, 16'h5555);
        dirty_clr = 1'b0;
        chk("dirty_race", {8'h00, dirty}, 16'h0020);
        chk_all("dirty");

        // same-cycle visibility of a write
        rd_addr_b = 3'd2;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF;
        #1;
`ifdef CPU_REGISTER_BANK_BYPASS_EN
        chk("byp_same", rd_data_b, 16'hBEEF);
`else
        chk("byp_same", rd_data_b, 16'(m_reg[2]));
`endif
        tick();
        wr_en = 1'b0;
        chk("byp_next", rd_data_b, 16'hBEEF);

        // async reset between edges with write and increment pending
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h7777; pc_inc = 1'b1;
        rd_addr_a = 3'd4; rd_addr_b = 3'd7;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("arst");
        @(posedge clk);
        #1;
        wr_en = 1'b0; pc_inc = 1'b0;
        rst = 1'b0;
        tick();
        chk_all("arst_rel");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            wr_en     = ($urandom_range(0, 99) < 60);
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
            pc_inc    = ($urandom_range(0, 99) < 50);
            freeze    = ($urandom_range(0, 99) < 25);
            dirty_clr = ($urandom_range(0, 99) < 15);
            rd_addr_a = 3'($urandom_range(0, 7));
            rd_addr_b = 3'($urandom_range(0, 7));
            #1;
            chk_reads("rnd_pre");
            tick();
            chk_all("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
